// File: rtl/fetch_unit.sv
// fetch_unit: program counter, single-outstanding imem fetch and prefetch FIFO
// feeding decode. Epoch tags discard fetches left in flight across a redirect.
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [15:0]     imem_rdata,
   input  logic            branch_en,
   input  logic [PC_W-1:0] branch_target,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [3:0]      dec_cmd,
   output logic [3:0]      dec_rA,
   output logic [3:0]      dec_rB,
   output logic [3:0]      dec_rC,
   output logic [PC_W-1:0] dec_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_fpc;
   logic            r_outst;
   logic            r_tag;
   logic            r_epoch;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [15:0]     r_instr [DEPTH];
   logic [PC_W-1:0] r_ipc   [DEPTH];

   logic            w_empty;
   logic            w_resp;
   logic            w_push;
   logic            w_pop;
   logic            w_issue;
   logic [CW-1:0]   w_occ;
   logic [15:0]     w_head;

   assign w_empty = (r_count == '0);
   assign w_resp  = imem_rvalid && r_outst;
   assign w_push  = w_resp && (r_tag == r_epoch) && !branch_en && !reset;
   assign w_pop   = !w_empty && dec_ready && !branch_en && !reset;

   always_comb begin
      w_occ = r_count;
      if (w_push) w_occ = w_occ + CW'(1);
      if (w_pop)  w_occ = w_occ - CW'(1);
   end

   // Room is checked after this cycle's push/pop, so the returning word
   // of the newly issued fetch always has a free slot.
   assign w_issue = !reset && !branch_en
                 && (!r_outst || imem_rvalid)
                 && (w_occ < CW'(DEPTH));

   assign imem_req  = w_issue;
   assign imem_addr = r_pc;

   assign dec_valid = !w_empty && !reset;
   assign w_head    = dec_valid ? r_instr[r_rptr] : '0;
   assign dec_cmd   = w_head[15:12];
   assign dec_rA    = w_head[11:8];
   assign dec_rB    = w_head[7:4];
   assign dec_rC    = w_head[3:0];
   assign dec_pc    = dec_valid ? r_ipc[r_rptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_fpc   <= RESET_PC;
         r_outst <= 1'b0;
         r_tag   <= 1'b0;
         r_epoch <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_issue) begin
            r_outst <= 1'b1;
            r_tag   <= r_epoch;
            r_fpc   <= r_pc;
         end else if (w_resp) begin
            r_outst <= 1'b0;
         end
         if (branch_en) begin
            r_pc    <= branch_target;
            r_epoch <= ~r_epoch;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_issue) r_pc <= r_pc + PC_W'(1);
            if (w_push)  r_wptr <= r_wptr + AW'(1);
            if (w_pop)   r_rptr <= r_rptr + AW'(1);
            r_count <= w_occ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr[r_wptr] <= imem_rdata;
         r_ipc[r_wptr]   <= r_fpc;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle controller and datapath.
- Holds the program counter (PC) and issues requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to decode over a valid/ready handshake, with fields pre-split: cmd feeds the controller; rA/rB/rC feed the register file.
- Takes branch redirects from the datapath (write to r15): flushes the FIFO and discards stale in-flight fetches.

Parameters:
- PC_W, 8, PC and instruction-memory address width.
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request this cycle; always accepted by memory.
- imem_addr  out  PC_W  fetch address (current PC).
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after request.
- imem_rdata  in  16  instruction word.
- branch_en  in  1  redirect pulse (branch resolved this cycle).
- branch_target  in  PC_W  redirect address.
- dec_valid  out  1  head instruction valid.
- dec_ready  in  1  decode consumes head this cycle.
- dec_cmd  out  4  instr[15:12].
- dec_rA  out  4  instr[11:8] (destination).
- dec_rB  out  4  instr[7:4].
- dec_rC  out  4  instr[3:0] (register or immediate).
- dec_pc  out  PC_W  address the head instruction was fetched from.

Behaviour:
- Reset (sync, takes priority over all inputs):
  - pc=RESET_PC, FIFO empty, outstanding=0, epoch=0.
  - imem_req=0 and dec_valid=0 during reset.
  - dec_* data outputs are 0 while the FIFO is empty.
  - Reset mid-operation drops FIFO contents and any in-flight fetch; a later imem_rvalid is ignored because outstanding=0.
- Request issue:
  - imem_req is combinational and asserts when all of the following hold:
    - !reset and !branch_en;
    - outstanding==0, or imem_rvalid is high this cycle;
    - occupancy after this cycle's push/pop is < DEPTH.
  - At most one fetch is in flight. Back-to-back 1-cycle-latency memory sustains 1 instruction/cycle.
  - On issue: imem_addr=pc; pc<=pc+1 modulo 2^PC_W (wraps from 2^PC_W−1 to 0); outstanding<=1; tag<=epoch.
- Response:
  - On imem_rvalid with outstanding==1, outstanding clears unless a new request is issued the same cycle.
  - The word is pushed with its fetch address only if tag==epoch and branch_en==0. Otherwise it is dropped.
  - imem_rvalid with outstanding==0 is ignored.
- Redirect (branch_en=1):
  - FIFO cleared; pc<=branch_target; epoch toggles; no request issued that cycle.
  - No pop that cycle: dec_ready is ignored.
  - The in-flight fetch stays outstanding and is discarded on return.
  - The first request to branch_target issues in the cycle after redirect if outstanding==0, else in the cycle its stale response returns.
- Decode side:
  - dec_valid = FIFO not empty. dec_* show the head entry, stable while dec_valid && !dec_ready.
  - Pop when dec_valid && dec_ready && !branch_en.
  - Push and pop in the same cycle are both performed, leaving occupancy unchanged.
  - Full FIFO blocks issue. Overflow is impossible because issue accounts for the outstanding slot.
- Latency: with 1-cycle memory, request at cycle T → rvalid at T+1 → dec_valid at T+2.
- Same-cycle priority: reset > branch_en > push/pop/issue.

Test Plan:
- Reset then 1-cycle memory, dec_ready=1, words 0x1234,0x2345,… → imem_addr 0,1,2,… on consecutive cycles; dec_valid from cycle 2; dec_cmd=1, dec_rA=2, dec_pc=0 first; then 1 instruction/cycle.
- dec_ready=0 for 10 cycles → exactly DEPTH=4 words buffered, imem_req low after 4 issues; release dec_ready → addresses 0..3 in order, no loss or duplicate, fetching resumes at 4.
- branch_en with branch_target=0x40 while FIFO holds 3 entries and one fetch is in flight (3-cycle memory) → dec_valid=0 next cycle; stale word not delivered; next delivered dec_pc=0x40.
- branch_en in the same cycle as imem_rvalid and dec_ready → returned word dropped, no pop, pc=target.
- PC=0xFF with PC_W=8 → next imem_addr=0x00; dec_pc sequence 0xFF,0x00.
- Assert reset for 1 cycle mid-stream with one fetch in flight → dec_valid=0 next cycle; a late imem_rvalid is ignored; fetch restarts at RESET_PC.
